clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Parametrised multi-channel fractional clock-enable generator. It runs on the board system clock and produces one-cycle clock-enable pulses at runtime-programmable rates using per-channel phase accumulators (DDS style). It complements the fixed-ratio MMCM pixel-clock wrapper: display timing, pixel-fetch and peripheral logic can step at arbitrary fractional rates in a single clock domain, and those rates can be changed without reconfiguring the MMCM. A `locked` status with settle sequencing tells downstream logic when the enables are stable.

## Interface
- `CHANNELS`, 2: number of independent enable channels, ≥1.
- `ACC_W`, 32: accumulator and increment width, ≥8.
- `LOCK_CYCLES`, 1024: clk_in cycles from last rate change or start to `locked`, ≥1.
- `CH_W` (localparam): max(1, $clog2(CHANNELS)).

Ports:
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = accumulators advance, 0 = stop and clear.
- `inc_valid`  in  1  increment-write request.
- `inc_ready`  out  1  increment-write accept.
- `inc_ch`  in  CH_W  target channel.
- `inc_data`  in  ACC_W  new increment; output rate = f_clk·inc/2^ACC_W.
- `ce_out`  out  CHANNELS  one-cycle enable pulse per channel.
- `locked`  out  1  enables stable at programmed rates.
- `clk_div_out`  out  CHANNELS  50% square wave at half the ce rate (only with CLKGEN_DIVOUT_EN).

## Operation
- Per channel: `acc`, `inc` (active), `pend` + `pend_v` (pending update).
- Write: the handshake completes when `inc_valid & inc_ready`. `inc_ready` = !`pend_v[inc_ch]` (combinational on `inc_ch`). `inc_ch` ≥ CHANNELS: accepted and discarded.
- A pending update is applied at the channel's next carry, so no truncated period is produced. If the active `inc` is 0, or `run`=0, it is applied on the next cycle. Applying it clears `pend_v`.
- Each cycle with `run`=1: {carry, acc} <= acc + inc (ACC_W+1-bit sum, wrap modulo 2^ACC_W). `ce_out[c]` <= carry.
- `inc`=0: the channel is silent. `inc`=2^ACC_W−1: carry on all but the first add.
- `run`=0: all `acc` cleared to 0, `ce_out` held 0, increments retained.
- Lock FSM:
  - IDLE (`locked`=0): goes to SETTLE when `run`=1; the counter loads LOCK_CYCLES−1.
  - SETTLE (`locked`=0): the counter decrements each cycle. At 0 it goes to LOCKED. Any increment apply reloads the counter.
  - LOCKED (`locked`=1): an increment apply goes to SETTLE and reloads the counter.
  - Any state: `run`=0 goes to IDLE.
- If a write and an apply hit the same channel in the same cycle, the apply uses the old `pend` and the new value becomes pending (`inc_ready` was low, so this only happens via the free-running apply rule — it is not permitted).
- Reset values: `acc`, `inc`, `pend`=0; `pend_v`=0; `ce_out`=0; `clk_div_out`=0; `locked`=0; FSM IDLE; `inc_ready`=1.

## Timing
- `ce_out` latency: a carry from the add in cycle n shows as `ce_out`=1 in cycle n+1, for exactly one cycle.
- After `run` rises in cycle 0, the first add is in cycle 1.
- A new `inc` takes effect on the add in the cycle after the apply.
- `locked` rises exactly LOCK_CYCLES cycles after entering SETTLE with no intervening apply.
- `run` falling: `ce_out` and `locked` are 0 the next cycle.
- Asserting `reset_n` low mid-operation clears everything immediately (asynchronous). Release is synchronous to clk_in.

## Configuration
- `CLKGEN_DIVOUT_EN` defined: `clk_div_out[c]` toggles on each cycle where `ce_out[c]`=1, registered. It is cleared when `run`=0.
- Undefined: the `clk_div_out` port and toggle flops are absent. All other behaviour is identical.

## Test plan
- ACC_W=32, ch0 inc=0x8000_0000, `run`=1 → `ce_out[0]` pulses every 2nd cycle, first pulse at cycle 3; `locked`=1 after 1024 cycles.
- inc=1082331759 (25.2 MHz from 100 MHz) over 10^6 cycles → exactly 251999 or 252000 pulses, spacing always 3 or 4 cycles.
- During LOCKED, write ch1 inc=0x4000_0000 (old 0x8000_0000) → `inc_ready` low until the next ch1 carry. After it, spacing is 4, never 1 or 3. `locked` drops for 1024 cycles.
- Second write to the same channel while pending → `inc_ready`=0 and the write stalls. The first value is applied; the second is accepted the cycle after the apply.
- `run` dropped mid-period, then raised → `ce_out`=0 and `locked`=0 next cycle. The restart phase is identical to the first start. `reset_n` pulse mid-run → all outputs 0 immediately, `inc_ready`=1.
- With CLKGEN_DIVOUT_EN, inc=0x8000_0000 → `clk_div_out[0]` has a period of 4 cycles and 50% duty.

Source files
------------

// File: rtl/clk_en_gen.sv
// Multi-channel DDS-style fractional clock-enable generator with lock/settle sequencing.
// Define CLKGEN_DIVOUT_EN to add a registered half-rate square wave per channel (clk_div_out).
module clk_en_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                run,
    input  logic                inc_valid,
    output logic                inc_ready,
    input  logic [CH_W-1:0]     inc_ch,
    input  logic [ACC_W-1:0]    inc_data,
    output logic [CHANNELS-1:0] ce_out,
    output logic                locked
`ifdef CLKGEN_DIVOUT_EN
    ,
    output logic [CHANNELS-1:0] clk_div_out
`endif
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StLocked} state_e;

    logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0][ACC_W-1:0] inc_q, inc_d;
    logic [CHANNELS-1:0][ACC_W-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0]            pend_v_q, pend_v_d;
    logic [CHANNELS-1:0]            ce_q, ce_d;
    logic [CHANNELS-1:0]            apply;
    logic                           run_q;
    logic                           adv;
    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    // Accumulators only advance once run has been seen for a full cycle.
    assign adv = run & run_q;

    // Out-of-range channels match no entry, so they are always ready and discarded.
    always_comb begin
        inc_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (inc_ch == CH_W'(c)) inc_ready = ~pend_v_q[c];
        end
    end

    always_comb begin
        logic [ACC_W:0] sum;
        acc_d    = acc_q;
        inc_d    = inc_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ce_d     = '0;
        apply    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum     = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            ce_d[c] = adv & sum[ACC_W];
            if (!run) begin
                acc_d[c] = '0;
            end else if (adv) begin
                acc_d[c] = sum[ACC_W-1:0];
            end
            // Swap rates only on a period boundary so no truncated period is emitted.
            apply[c] = pend_v_q[c] & (ce_d[c] | (inc_q[c] == '0) | ~adv);
            if (apply[c]) begin
                inc_d[c]    = pend_q[c];
                pend_v_d[c] = 1'b0;
            end
            if (inc_valid && inc_ready && (inc_ch == CH_W'(c))) begin
                pend_d[c]   = inc_data;
                pend_v_d[c] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                end
                StSettle: begin
                    if (|apply) begin
                        cnt_d = CntLoad;
                    end else if (cnt_q == '0) begin
                        state_d = StLocked;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StLocked: begin
                    if (|apply) begin
                        state_d = StSettle;
                        cnt_d   = CntLoad;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            inc_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= '0;
            ce_q     <= '0;
            run_q    <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ce_q     <= ce_d;
            run_q    <= run;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ce_out = ce_q;
    assign locked = (state_q == StLocked);

`ifdef CLKGEN_DIVOUT_EN
    logic [CHANNELS-1:0] div_q, div_d;

    always_comb begin
        div_d = run ? (div_q ^ ce_q) : '0;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign clk_div_out = div_q;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: directed steps plus randomized writes, compared
// each cycle against a closed-form phase model (acc = base + k*inc per rate segment).
module tb_clk_en_gen;

    localparam int CH = 3;
    localparam int W  = 32;
    localparam int LC = 1024;
    localparam int CW = 2;
    localparam longint unsigned MASK = 64'hFFFF_FFFF;

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic          inc_valid = 1'b0;
    logic          inc_ready;
    logic [CW-1:0] inc_ch = '0;
    logic [W-1:0]  inc_data = '0;
    logic [CH-1:0] ce_out;
    logic          locked;
`ifdef CLKGEN_DIVOUT_EN
    logic [CH-1:0] clk_div_out;
`endif

    clk_en_gen #(
        .CHANNELS   (CH),
        .ACC_W      (W),
        .LOCK_CYCLES(LC)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .run      (run),
        .inc_valid(inc_valid),
        .inc_ready(inc_ready),
        .inc_ch   (inc_ch),
        .inc_data (inc_data),
        .ce_out   (ce_out),
        .locked   (locked)
`ifdef CLKGEN_DIVOUT_EN
        ,
        .clk_div_out(clk_div_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: each channel's phase is base + k*inc since its last rate change.
    longint unsigned m_base[CH];
    longint unsigned m_k[CH];
    longint unsigned m_inc[CH];
    longint unsigned m_pend[CH];
    bit              m_pendv[CH];
    logic [CH-1:0]   m_ce;
    logic [CH-1:0]   m_div;
    bit              m_locked;
    bit              m_idle;
    bit              m_run_prev;
    longint          m_edge;
    longint          m_settle;

    int n_total = 0;
    int n_pass  = 0;
    bit dut_acc;
    int last_tries;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    function automatic longint unsigned m_acc(input int c);
        return (m_base[c] + m_k[c] * m_inc[c]) & MASK;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_base[c] = 0; m_k[c] = 0; m_inc[c] = 0; m_pend[c] = 0; m_pendv[c] = 0;
        end
        m_ce = '0; m_div = '0; m_locked = 0; m_idle = 1; m_run_prev = 0;
    endtask

    // One clock: check inc_ready, advance the model, clock the DUT, check outputs.
    task automatic step();
        bit exp_rdy, any_apply, adv;
        int ch;
        longint unsigned a;
        #1;
        ch = int'(inc_ch);
        exp_rdy = (ch >= CH) ? 1'b1 : !m_pendv[ch];
        check("inc_ready", inc_ready, exp_rdy);
        dut_acc = inc_valid && inc_ready;
        adv = run && m_run_prev;
        any_apply = 0;
        m_div = run ? (m_div ^ m_ce) : '0;
        for (int c = 0; c < CH; c++) begin
            a = m_acc(c);
            m_ce[c] = adv && ((a + m_inc[c]) > MASK);
            if (adv) begin
                m_k[c]++;
            end else if (!run) begin
                m_base[c] = 0; m_k[c] = 0;
            end
            if (m_pendv[c] && (m_ce[c] || m_inc[c] == 0 || !adv)) begin
                m_base[c] = m_acc(c); m_k[c] = 0;
                m_inc[c] = m_pend[c]; m_pendv[c] = 0;
                any_apply = 1;
            end
        end
        if (inc_valid && exp_rdy && ch < CH) begin
            m_pend[ch] = 64'(inc_data); m_pendv[ch] = 1;
        end
        if (!run) begin
            m_idle = 1;
        end else if (m_idle) begin
            m_idle = 0; m_settle = m_edge;
        end else if (any_apply) begin
            m_settle = m_edge;
        end
        m_locked = !m_idle && ((m_edge - m_settle) >= LC);
        m_run_prev = run;
        m_edge++;
        @(posedge clk_in);
        #1;
        check("ce_out", ce_out, m_ce);
        check("locked", locked, m_locked);
`ifdef CLKGEN_DIVOUT_EN
        check("clk_div_out", clk_div_out, m_div);
`endif
    endtask

    task automatic write(input int ch, input longint unsigned d);
        inc_valid = 1'b1; inc_ch = CW'(ch); inc_data = W'(d);
        dut_acc = 0; last_tries = 0;
        while (!dut_acc && last_tries < 1000) begin
            step();
            last_tries++;
        end
        inc_valid = 1'b0;
        check("write_accept", dut_acc, 1);
    endtask

    task automatic gaps(input int c, input int ncyc, output int np, output int gmin,
                        output int gmax);
        int last;
        last = -1; np = 0; gmin = 1 << 30; gmax = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (ce_out[c]) begin
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
                np++;
            end
        end
    endtask

    initial begin
        int first, np, gmin, gmax, r, sel;
        longint unsigned v;
        model_reset();
        m_edge = 0; m_settle = 0;
        #12;
        check("rst_ce_out", ce_out, 0);
        check("rst_locked", locked, 0);
        check("rst_inc_ready", inc_ready, 1);
        @(posedge clk_in);
        #1 reset_n = 1'b1;

        // Programming while stopped applies on the next cycle.
        write(0, 64'h8000_0000);
        write(1, 64'h8000_0000);
        repeat (3) step();

        // Start: first add one cycle after run rises, first pulse in cycle 3.
        run = 1'b1;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (ce_out[0] && first < 0) first = i;
        end
        check("first_pulse_cycle", first, 3);
        repeat (1100) step();
        check("locked_after_settle", locked, 1);

        // Rate change on ch1 while locked: spacing 2 -> 4, lock re-settles.
        write(1, 64'h4000_0000);
        #1 check("ready_low_pending", inc_ready, 0);
        repeat (4) step();
        gaps(1, 40, np, gmin, gmax);
        check("ch1_gap_min", gmin, 4);
        check("ch1_gap_max", gmax, 4);
        check("settle_restarted", locked, 0);

        // Back-to-back writes to one channel: the second stalls until the first applies.
        write(0, 64'h4000_0000);
        write(0, 64'h2000_0000);
        check("second_write_stalled", (last_tries > 1), 1);

        // Drop run mid-period, then restart.
        repeat (7) step();
        run = 1'b0;
        step();
        check("run_drop_ce", ce_out, 0);
        check("run_drop_locked", locked, 0);
        repeat (5) step();
        run = 1'b1;
        repeat (300) step();

        // Randomized writes (incl. out-of-range channel, 0, all-ones) and rare run drops.
        repeat (12000) begin
            r = int'($urandom_range(0, 999));
            if (r < 30) begin
                sel = int'($urandom_range(0, 5));
                case (sel)
                    0:       v = 0;
                    1:       v = MASK;
                    2:       v = 64'h8000_0000;
                    default: v = 64'($urandom_range(32'h0100_0000, 32'hFFFF_FFFF));
                endcase
                write(int'($urandom_range(0, 3)), v);
            end else if (r == 30) begin
                run = 1'b0;
                repeat (int'($urandom_range(1, 4))) step();
                run = 1'b1;
            end else begin
                step();
            end
        end

        // 25.2 MHz from 100 MHz: spacing always 3 or 4.
        write(2, 64'd1082331759);
        repeat (300) step();
        gaps(2, 20000, np, gmin, gmax);
        check("frac_gap_min", gmin, 3);
        check("frac_gap_max", gmax, 4);
        check("frac_count", (np >= 5039 && np <= 5041), 1);

        // Asynchronous reset pulse mid-run.
        @(posedge clk_in);
        #3 reset_n = 1'b0;
        #1;
        check("rstpulse_ce_out", ce_out, 0);
        check("rstpulse_locked", locked, 0);
        check("rstpulse_inc_ready", inc_ready, 1);
        model_reset();
        @(posedge clk_in);
        #1 reset_n = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
